// File: rtl/hardnet_input_streamer.sv
// Frame loader in front of hardnet: buffers one pixel frame, replays it as
// dataWidth words, then waits for the classification result before taking
// the next frame. Only one frame is ever in flight.
module hardnet_input_streamer #(
  parameter int unsigned dataWidth = 16,
  parameter int unsigned pixWidth  = 8,
  parameter int unsigned numInput  = 784,
  parameter int unsigned pixShift  = 0,
  parameter int unsigned gap       = 0,
  parameter int unsigned timeout   = 1048576
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [pixWidth-1:0]  s_pixel,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [dataWidth-1:0] data_out,
  output logic                 data_out_valid,
  input  logic [31:0]          result_in,
  input  logic                 result_valid,
  output logic [31:0]          class_out,
  output logic                 class_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 timeout_err,
  output logic [15:0]          frame_count
);

  localparam int unsigned PtrW = (numInput > 1) ? $clog2(numInput) : 1;
  localparam int unsigned GapW = (gap > 0) ? $clog2(gap + 1) : 1;
  localparam int unsigned TmrW = $clog2(timeout + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(numInput - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(gap);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(timeout - 1);

  typedef enum logic [1:0] {StLoad, StStream, StWaitRes} state_e;

  state_e                 r_state, w_state_nxt;
  logic [PtrW-1:0]        r_wr_ptr, w_wr_ptr_nxt;
  logic [PtrW-1:0]        r_rd_ptr, w_rd_ptr_nxt;
  logic [GapW-1:0]        r_gap_cnt, w_gap_cnt_nxt;
  logic [TmrW-1:0]        r_timer, w_timer_nxt;
  logic                   r_rd_valid, w_rd_valid_nxt;
  logic [pixWidth-1:0]    r_rd_data;
  logic [pixWidth-1:0]    r_ram [numInput];

  logic                   r_s_ready, w_s_ready_nxt;
  logic [dataWidth-1:0]   r_data_out, w_data_out_nxt;
  logic                   r_data_out_valid, w_data_out_valid_nxt;
  logic [31:0]            r_class_out, w_class_out_nxt;
  logic                   r_class_valid, w_class_valid_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_frame_err, w_frame_err_nxt;
  logic                   r_timeout_err, w_timeout_err_nxt;
  logic [15:0]            r_frame_count, w_frame_count_nxt;

  logic                   w_accept;
  logic                   w_issue;
  logic [dataWidth-1:0]   w_pix_word;

  // s_ready is only ever high in StLoad, so this also implies the state.
  assign w_accept   = s_valid & r_s_ready;
  assign w_issue    = (r_state == StStream) && (r_gap_cnt == '0);
  assign w_pix_word = dataWidth'(r_rd_data) << pixShift;

  // Frame buffer: write on accepted pixel, registered read on each issue slot.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_ram[r_wr_ptr] <= s_pixel;
    end
    if (w_issue) begin
      r_rd_data <= r_ram[r_rd_ptr];
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= StLoad;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_gap_cnt        <= '0;
      r_timer          <= '0;
      r_rd_valid       <= 1'b0;
      r_s_ready        <= 1'b0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
      r_class_out      <= '0;
      r_class_valid    <= 1'b0;
      r_busy           <= 1'b0;
      r_frame_err      <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_frame_count    <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_wr_ptr         <= w_wr_ptr_nxt;
      r_rd_ptr         <= w_rd_ptr_nxt;
      r_gap_cnt        <= w_gap_cnt_nxt;
      r_timer          <= w_timer_nxt;
      r_rd_valid       <= w_rd_valid_nxt;
      r_s_ready        <= w_s_ready_nxt;
      r_data_out       <= w_data_out_nxt;
      r_data_out_valid <= w_data_out_valid_nxt;
      r_class_out      <= w_class_out_nxt;
      r_class_valid    <= w_class_valid_nxt;
      r_busy           <= w_busy_nxt;
      r_frame_err      <= w_frame_err_nxt;
      r_timeout_err    <= w_timeout_err_nxt;
      r_frame_count    <= w_frame_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_timer_nxt       = r_timer;
    w_class_out_nxt   = r_class_out;
    w_class_valid_nxt = 1'b0;
    w_frame_err_nxt   = 1'b0;
    w_timeout_err_nxt = 1'b0;
    w_frame_count_nxt = r_frame_count;

    unique case (r_state)
      StLoad: begin
        if (w_accept) begin
          if (r_wr_ptr == LastPtr) begin
            w_wr_ptr_nxt = '0;
            if (s_last) begin
              w_state_nxt   = StStream;
              w_rd_ptr_nxt  = '0;
              w_gap_cnt_nxt = '0;
            end else begin
              w_frame_err_nxt = 1'b1;
            end
          end else if (s_last) begin
            // Early s_last: drop the partial frame.
            w_frame_err_nxt = 1'b1;
            w_wr_ptr_nxt    = '0;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + PtrW'(1);
          end
        end
      end
      StStream: begin
        if (r_gap_cnt != '0) begin
          w_gap_cnt_nxt = r_gap_cnt - GapW'(1);
        end else begin
          w_gap_cnt_nxt = GapLoad;
          if (r_rd_ptr == LastPtr) begin
            w_state_nxt  = StWaitRes;
            w_rd_ptr_nxt = '0;
            w_timer_nxt  = '0;
          end else begin
            w_rd_ptr_nxt = r_rd_ptr + PtrW'(1);
          end
        end
      end
      StWaitRes: begin
        // A result on the final timer cycle still wins over the timeout.
        if (result_valid) begin
          w_class_out_nxt   = result_in;
          w_class_valid_nxt = 1'b1;
          w_frame_count_nxt = r_frame_count + 16'd1;
          w_state_nxt       = StLoad;
        end else if (r_timer == TmrLast) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = StLoad;
        end else begin
          w_timer_nxt = r_timer + TmrW'(1);
        end
      end
      default: w_state_nxt = StLoad;
    endcase

    w_s_ready_nxt        = (w_state_nxt == StLoad);
    w_busy_nxt           = (w_state_nxt != StLoad);
    w_rd_valid_nxt       = w_issue;
    w_data_out_valid_nxt = r_rd_valid;
    w_data_out_nxt       = r_rd_valid ? w_pix_word : r_data_out;
  end

  assign s_ready        = r_s_ready;
  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign class_out      = r_class_out;
  assign class_valid    = r_class_valid;
  assign busy           = r_busy;
  assign frame_err      = r_frame_err;
  assign timeout_err    = r_timeout_err;
  assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_hardnet_input_streamer.sv
// Bench for hardnet_input_streamer. Unit 0 uses default parameters, unit 1 uses
// pixShift=4, gap=2, timeout=1000. Expected words are queued when a good frame
// is sent and popped by a monitor as data_out_valid appears.
module tb_hardnet_input_streamer;

  localparam int NUM = 784;

  logic        clock = 1'b0;
  logic        rst_n          [2];
  logic [7:0]  s_pixel        [2];
  logic        s_valid        [2];
  logic        s_last         [2];
  logic        s_ready        [2];
  logic [15:0] data_out       [2];
  logic        data_out_valid [2];
  logic [31:0] result_in      [2];
  logic        result_valid   [2];
  logic [31:0] class_out      [2];
  logic        class_valid    [2];
  logic        busy           [2];
  logic        frame_err      [2];
  logic        timeout_err    [2];
  logic [15:0] frame_count    [2];

  always #5 clock = ~clock;

  hardnet_input_streamer u_dut0 (
    .clock(clock), .reset(rst_n[0]), .s_pixel(s_pixel[0]), .s_valid(s_valid[0]),
    .s_last(s_last[0]), .s_ready(s_ready[0]), .data_out(data_out[0]),
    .data_out_valid(data_out_valid[0]), .result_in(result_in[0]),
    .result_valid(result_valid[0]), .class_out(class_out[0]), .class_valid(class_valid[0]),
    .busy(busy[0]), .frame_err(frame_err[0]), .timeout_err(timeout_err[0]),
    .frame_count(frame_count[0])
  );

  hardnet_input_streamer #(.pixShift(4), .gap(2), .timeout(1000)) u_dut1 (
    .clock(clock), .reset(rst_n[1]), .s_pixel(s_pixel[1]), .s_valid(s_valid[1]),
    .s_last(s_last[1]), .s_ready(s_ready[1]), .data_out(data_out[1]),
    .data_out_valid(data_out_valid[1]), .result_in(result_in[1]),
    .result_valid(result_valid[1]), .class_out(class_out[1]), .class_valid(class_valid[1]),
    .busy(busy[1]), .frame_err(frame_err[1]), .timeout_err(timeout_err[1]),
    .frame_count(frame_count[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  int first_cyc     [2];
  bit first_pending [2];
  int last_vld      [2];
  int spacing       [2];
  int ferr_cnt      [2];
  int cls_cnt       [2];
  int tmo_cnt       [2];
  int vld_cnt       [2];

  logic [15:0] mon_exp;
  bit          mon_have;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor and pulse counters.
  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (data_out_valid[u]) begin
        vld_cnt[u]++;
        mon_have = 1'b0;
        if (u == 0 && exp_q0.size() > 0) begin
          mon_have = 1'b1;
          mon_exp  = exp_q0.pop_front();
        end else if (u == 1 && exp_q1.size() > 0) begin
          mon_have = 1'b1;
          mon_exp  = exp_q1.pop_front();
        end
        if (!mon_have) check("extra_word", 32'd1, 32'd0);
        else check("word", data_out[u], mon_exp);
        if (first_pending[u]) begin
          check("first_latency", cyc, first_cyc[u]);
          first_pending[u] = 1'b0;
        end else begin
          check("spacing", cyc - last_vld[u], spacing[u]);
        end
        last_vld[u] = cyc;
      end
      if (frame_err[u])   ferr_cnt[u]++;
      if (class_valid[u]) cls_cnt[u]++;
      if (timeout_err[u]) tmo_cnt[u]++;
    end
  end

  task automatic push_frame(input int u, input logic [7:0] base, input logic [7:0] step);
    logic [7:0]  p;
    logic [15:0] w;
    for (int k = 0; k < NUM; k++) begin
      p = base + 8'(k) * step;
      w = {8'h00, p} << ((u == 1) ? 4 : 0);
      if (u == 0) exp_q0.push_back(w);
      else exp_q1.push_back(w);
    end
  endtask

  // Sends n pixels; s_last on index last_at (-1 = never).
  task automatic send_frame(input int u, input int n, input int last_at,
                            input logic [7:0] base, input logic [7:0] step);
    int  waitc;
    bit  good;
    good = (n == NUM) && (last_at == NUM - 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      waitc = 0;
      while (!s_ready[u] && waitc < 100) begin
        @(negedge clock);
        waitc++;
      end
      if (!s_ready[u]) begin
        check("s_ready_wait", 32'd0, 32'd1);
        s_valid[u] = 1'b0;
        return;
      end
      s_pixel[u] = base + 8'(i) * step;
      s_valid[u] = 1'b1;
      s_last[u]  = (i == last_at);
      if (good && i == n - 1) begin
        first_cyc[u]     = cyc + 3;
        first_pending[u] = 1'b1;
        push_frame(u, base, step);
      end
      @(posedge clock);
    end
    @(negedge clock);
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
  endtask

  task automatic wait_drain(input int u, input int budget);
    int i;
    i = 0;
    while (((u == 0) ? exp_q0.size() : exp_q1.size()) != 0 && i < budget) begin
      @(negedge clock);
      i++;
    end
    check("drain_left", (u == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
  endtask

  task automatic give_result(input int u, input logic [31:0] val, input logic [15:0] exp_cnt);
    int c0;
    c0 = cls_cnt[u];
    @(negedge clock);
    result_in[u]    = val;
    result_valid[u] = 1'b1;
    @(negedge clock);
    result_valid[u] = 1'b0;
    check("class_valid_hi", class_valid[u], 32'd1);
    check("class_out", class_out[u], val);
    check("frame_count", frame_count[u], exp_cnt);
    check("s_ready_after_res", s_ready[u], 32'd1);
    check("busy_after_res", busy[u], 32'd0);
    @(negedge clock);
    check("class_valid_pulse", class_valid[u], 32'd0);
    check("class_pulses", cls_cnt[u] - c0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int c0;
    int v0;
    spacing[0] = 1;
    spacing[1] = 3;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; s_pixel[u] = '0; s_valid[u] = 1'b0; s_last[u] = 1'b0;
      result_in[u] = '0; result_valid[u] = 1'b0;
      first_pending[u] = 1'b0; ferr_cnt[u] = 0; cls_cnt[u] = 0; tmo_cnt[u] = 0;
      vld_cnt[u] = 0; last_vld[u] = 0; first_cyc[u] = 0;
    end

    // Reset state
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_s_ready", s_ready[u], 32'd0);
      check("rst_dvalid", data_out_valid[u], 32'd0);
      check("rst_data_out", data_out[u], 32'd0);
      check("rst_busy", busy[u], 32'd0);
      check("rst_frame_count", frame_count[u], 32'd0);
    end
    repeat (3) @(negedge clock);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clock);
    check("s_ready_after_rst0", s_ready[0], 32'd1);
    check("s_ready_after_rst1", s_ready[1], 32'd1);

    // Counting frame, then a result 50 cycles after the stream
    send_frame(0, NUM, NUM - 1, 8'd0, 8'd1);
    @(negedge clock);
    check("busy_stream", busy[0], 32'd1);
    check("s_ready_stream", s_ready[0], 32'd0);
    wait_drain(0, NUM + 20);
    check("busy_wait_res", busy[0], 32'd1);
    repeat (50) @(negedge clock);
    give_result(0, 32'd7, 16'd1);

    // result_valid in LOAD is ignored
    result_in[0]    = 32'd99;
    result_valid[0] = 1'b1;
    @(negedge clock);
    result_valid[0] = 1'b0;
    check("ignored_res_cv", class_valid[0], 32'd0);
    check("ignored_res_class", class_out[0], 32'd7);

    // Early s_last on pixel 99
    c0 = ferr_cnt[0];
    v0 = vld_cnt[0];
    send_frame(0, 100, 99, 8'd3, 8'd5);
    repeat (20) @(negedge clock);
    check("early_last_ferr", ferr_cnt[0] - c0, 32'd1);
    check("early_last_novalid", vld_cnt[0] - v0, 32'd0);
    check("early_last_ready", s_ready[0], 32'd1);

    // Full-length frame missing s_last
    c0 = ferr_cnt[0];
    send_frame(0, NUM, -1, 8'd9, 8'd1);
    repeat (10) @(negedge clock);
    check("no_last_ferr", ferr_cnt[0] - c0, 32'd1);
    check("no_last_novalid", vld_cnt[0] - v0, 32'd0);

    // Next good frame streams normally
    send_frame(0, NUM, NUM - 1, 8'd5, 8'd3);
    wait_drain(0, NUM + 20);
    repeat (5) @(negedge clock);
    give_result(0, 32'h1234_5678, 16'd2);

    // Reset mid-stream
    send_frame(0, NUM, NUM - 1, 8'd77, 8'd11);
    repeat (100) @(negedge clock);
    #2;
    rst_n[0] = 1'b0;
    exp_q0.delete();
    first_pending[0] = 1'b0;
    #1;
    check("mid_rst_dvalid", data_out_valid[0], 32'd0);
    check("mid_rst_data", data_out[0], 32'd0);
    check("mid_rst_busy", busy[0], 32'd0);
    check("mid_rst_s_ready", s_ready[0], 32'd0);
    check("mid_rst_class", class_out[0], 32'd0);
    check("mid_rst_count", frame_count[0], 32'd0);
    repeat (3) @(negedge clock);
    rst_n[0] = 1'b1;
    @(negedge clock);
    check("post_rst_ready", s_ready[0], 32'd1);
    send_frame(0, NUM, NUM - 1, 8'd200, 8'd13);
    wait_drain(0, NUM + 20);
    give_result(0, 32'd42, 16'd1);

    // Unit 1: shifted words with gaps, then timeout
    send_frame(1, NUM, NUM - 1, 8'hAB, 8'd7);
    wait_drain(1, 3 * NUM + 20);
    c0 = 0;
    while (!timeout_err[1] && c0 < 1100) begin
      @(negedge clock);
      c0++;
    end
    check("timeout_seen", timeout_err[1], 32'd1);
    check("timeout_delay", cyc - last_vld[1], 32'd999);
    check("timeout_count", frame_count[1], 32'd0);
    check("timeout_ready", s_ready[1], 32'd1);
    check("timeout_busy", busy[1], 32'd0);
    @(negedge clock);
    check("timeout_pulse", timeout_err[1], 32'd0);
    check("timeout_pulses", tmo_cnt[1], 32'd1);
    check("timeout_nocls", cls_cnt[1], 32'd0);
    check("unit0_no_timeout", tmo_cnt[0], 32'd0);
    check("unit1_words", vld_cnt[1], NUM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
